onehot_pulse_decoder: RTL and testbench
=======================================

Name: onehot_pulse_decoder

Overview:
- Sequential inverse of the 4-to-2 priority encoder.
- Accepts an encoded index plus a valid flag, in the same in/v pairing the encoder produces, and drives the matching one-hot line for HOLD clock cycles.
- Has a one-entry pending buffer, so back-to-back requests play out with no gap.
- Sits downstream of the priority encoder to regenerate timed one-hot strobes, for example channel enables.

Parameters:
- N, 4: number of one-hot outputs.
- IDX_W, 2: index width; must satisfy 2**IDX_W >= N.
- HOLD, 4: cycles each one-hot pulse is held; must be >= 1.
- CNT_W, 3: hold counter width; must satisfy 2**CNT_W > HOLD.

Ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in, input, IDX_W: encoded index to decode.
- v, input, 1: in is valid this cycle.
- ready, output, 1: block can accept a request this cycle.
- out, output, N: one-hot pulse output; all zeros when idle.
- busy, output, 1: a pulse is in progress (out != 0).
- done, output, 1: high during the final cycle of each pulse.
- err, output, 1: one-cycle flag, high for an attempted index >= N.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, out=0, counter=0, pending empty, busy=0, done=0, err=0. ready=1 once rst deasserts.
- Reset mid-pulse aborts immediately: out drops to 0 and the pending entry is discarded.
- Accept condition: v && ready && (in < N), sampled at a rising edge.
- Invalid index: v && ready && (in >= N) is not accepted. err=1 for the following cycle; no other state changes. This cannot occur when N == 2**IDX_W.
- ready = !pending_valid, a combinational function of registered state only.
- State IDLE: out=0, busy=0.
  - Accept at edge k: out=(1<<in) from cycle k+1, counter=HOLD-1, go to ACTIVE.
- State ACTIVE: out holds its one-hot value and busy=1.
  - Counter decrements each cycle; done=1 when counter==0.
- Accept while ACTIVE and counter != 0: request is stored in pending; ready drops to 0 next cycle.
- End of pulse, at the edge leaving the counter==0 cycle:
  - Pending valid: load pending index into out, counter=HOLD-1, clear pending, stay ACTIVE. out switches directly between one-hot values with no zero cycle.
  - Else, v && ready && in<N in that same cycle: load directly as above. A request arriving in the done cycle does not pass through pending.
  - Else: out=0, go to IDLE.
- Latency: request accepted at edge k produces out high for cycles k+1 through k+HOLD, with done in cycle k+HOLD.
- HOLD=1: every ACTIVE cycle is a done cycle. Pending is never used, so ready stays 1 and back-to-back accepts give consecutive one-cycle pulses.
- Simultaneous end-of-pulse and a new request with pending full: ready=0, so the new request is not accepted; the upstream holds v.
- out is always zero or exactly one-hot; done implies busy; err never coincides with an accept.
- All outputs are registered except ready.

Decomposition:
- Shared package: state enum {IDLE, ACTIVE}; the one-hot decode function (index to 1<<index, width N); and the parameter-legality constant checks listed under Parameters.
- One natural sub-module, onehot_pulse_pending: a one-entry valid/data holding register with load/clear.
- The top level contains the FSM, the hold counter and the output register.

Test Plan (N=4, HOLD=4):
1. Reset release, then in=2'b10, v=1 for one cycle at edge k -> out=4'b0100 for cycles k+1..k+4; done=1 only in k+4; out=0 and busy=0 from k+5; ready=1 throughout.
2. Back-to-back: accept in=0 at edge k, then in=3 at edge k+1 -> ready=0 during k+2..k+4; out=4'b0001 for k+1..k+4, then 4'b1000 for k+5..k+8, no zero gap; done high in k+4 and k+8.
3. Request only in the done cycle: accept in=1 at edge k, then in=2, v=1 only during cycle k+4 -> out=4'b0010 for k+1..k+4, then 4'b0100 for k+5..k+8; pending never set.
4. Pending full: accept in=0, then in=1 while ACTIVE, then hold in=2, v=1 -> third request accepted only after pending drains; final pulse 4'b0100 for 4 cycles, and no request is lost or duplicated.
5. Asynchronous reset at a non-clock-edge instant mid-pulse, with pending holding in=3 -> out=0, busy=0, done=0 immediately, before the next edge; after release, out=0 and no 4'b1000 pulse appears.
6. Parameter variant N=3, IDX_W=2: request in=2'b11 in IDLE -> not accepted, err=1 for one cycle, out stays 0; next request in=2 produces out=3'b100 for 4 cycles.

Source files
------------

// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared types and helpers for the one-hot pulse decoder: FSM state encoding,
// index-to-one-hot decode and parameter legality check.
package onehot_pulse_decoder_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   localparam int unsigned MAX_N = 32;

   // Callers truncate the result to their own output width with a size cast.
   function automatic logic [MAX_N-1:0] onehot_decode(input logic [31:0] idx);
      onehot_decode = MAX_N'(1) << idx;
   endfunction

   function automatic bit params_legal(input int unsigned n,
                                       input int unsigned idx_w,
                                       input int unsigned hold,
                                       input int unsigned cnt_w);
      return (n >= 1) && (n <= MAX_N) && (idx_w >= 1) && (idx_w < 32) &&
             ((32'd1 << idx_w) >= n) && (hold >= 1) && (cnt_w >= 1) &&
             (cnt_w < 32) && ((32'd1 << cnt_w) > hold);
   endfunction

endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// Request/response bundle between an upstream index source (master) and the
// pulse decoder (slave).
interface onehot_pulse_decoder_if
   import onehot_pulse_decoder_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
);
   logic [IDX_W-1:0] in;
   logic             v;
   logic             ready;
   logic [N-1:0]     out;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output in, v,
      input  ready, out, busy, done, err
   );

   modport slave (
      input  in, v,
      output ready, out, busy, done, err
   );
endinterface

// File: rtl/onehot_pulse_decoder_pending.sv
// One-entry holding register for a request accepted while a pulse is still
// being played out.
module onehot_pulse_pending #(
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [IDX_W-1:0] idx_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             valid_q;
   logic [IDX_W-1:0] idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         idx_q   <= idx_i;
      end
   end

   assign valid_o = valid_q;
   assign idx_o   = idx_q;

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Sequential inverse of a priority encoder: turns an encoded index into a
// one-hot strobe held for HOLD cycles, with one request of look-ahead.
module onehot_pulse_decoder
   import onehot_pulse_decoder_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2,
   parameter int unsigned HOLD  = 4,
   parameter int unsigned CNT_W = 3
) (
   input logic                    clk,
   input logic                    rst,
   onehot_pulse_decoder_if.slave  bus
);

   if (!params_legal(N, IDX_W, HOLD, CNT_W)) begin : g_param_check
      $error("onehot_pulse_decoder: illegal parameter combination");
   end

   localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     out_q, out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             idx_ok;
   logic             ready;
   logic             accept;
   logic             invalid;
   logic             pend_load;
   logic             pend_clear;
   logic             pend_valid;
   logic [IDX_W-1:0] pend_idx;
   logic [N-1:0]     dec_in;
   logic [N-1:0]     dec_pend;

   // When every encodable index maps to an output there is nothing to reject.
   if (N == (32'd1 << IDX_W)) begin : g_idx_full
      assign idx_ok = 1'b1;
   end else begin : g_idx_part
      assign idx_ok = (32'(bus.in) < N);
   end

   assign ready    = !pend_valid;
   assign accept   = bus.v && ready && idx_ok;
   assign invalid  = bus.v && ready && !idx_ok;
   assign dec_in   = N'(onehot_decode(32'(bus.in)));
   assign dec_pend = N'(onehot_decode(32'(pend_idx)));

   onehot_pulse_pending #(
      .IDX_W (IDX_W)
   ) u_pending (
      .clk     (clk),
      .rst     (rst),
      .load_i  (pend_load),
      .clear_i (pend_clear),
      .idx_i   (bus.in),
      .valid_o (pend_valid),
      .idx_o   (pend_idx)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      out_d      = out_q;
      pend_load  = 1'b0;
      pend_clear = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACTIVE;
               cnt_d   = HOLD_M1;
               out_d   = dec_in;
            end
         end
         ACTIVE: begin
            if (cnt_q != '0) begin
               cnt_d     = cnt_q - CNT_W'(1);
               pend_load = accept;
            end else if (pend_valid) begin
               // Pending wins over a live request; ready is low here anyway.
               out_d      = dec_pend;
               cnt_d      = HOLD_M1;
               pend_clear = 1'b1;
            end else if (accept) begin
               out_d = dec_in;
               cnt_d = HOLD_M1;
            end else begin
               out_d   = '0;
               state_d = IDLE;
            end
         end
      endcase

      busy_d = (state_d == ACTIVE);
      done_d = (state_d == ACTIVE) && (cnt_d == '0);
      err_d  = invalid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.ready = ready;
   assign bus.out   = out_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Scoreboard bench for onehot_pulse_decoder: three instances (N=4/HOLD=4,
// N=3/HOLD=4, N=4/HOLD=1) checked every cycle against a pulse-schedule model.
module tb_onehot_pulse_decoder;

   localparam int NI = 3;
   localparam int NN [NI] = '{4, 3, 4};
   localparam int HH [NI] = '{4, 4, 1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int acc;
      int start;
      int fin;
   } pulse_t;

   pulse_t sched  [NI][$];
   int     err_at [NI][$];
   int     last_end [NI];

   bit drv_v  [NI];
   int drv_i  [NI];
   bit want_v [NI];
   int want_i [NI];
   bit took   [NI];

   int vectors     = 0;
   int miscompares = 0;

   onehot_pulse_decoder_if #(.N(4), .IDX_W(2)) bus0 ();
   onehot_pulse_decoder_if #(.N(3), .IDX_W(2)) bus1 ();
   onehot_pulse_decoder_if #(.N(4), .IDX_W(2)) bus2 ();

   assign bus0.v  = drv_v[0];
   assign bus0.in = 2'(drv_i[0]);
   assign bus1.v  = drv_v[1];
   assign bus1.in = 2'(drv_i[1]);
   assign bus2.v  = drv_v[2];
   assign bus2.in = 2'(drv_i[2]);

   onehot_pulse_decoder #(.N(4), .IDX_W(2), .HOLD(4), .CNT_W(3)) dut0 (
      .clk (clk), .rst (rst), .bus (bus0));
   onehot_pulse_decoder #(.N(3), .IDX_W(2), .HOLD(4), .CNT_W(3)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1));
   onehot_pulse_decoder #(.N(4), .IDX_W(2), .HOLD(1), .CNT_W(1)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2));

   // Ready is low in cycle c exactly when some scheduled pulse was accepted
   // before c but has not started yet (it sits in the one-entry buffer).
   function automatic bit m_ready(int k, int c);
      for (int j = 0; j < sched[k].size(); j++)
         if (sched[k][j].acc < c && c < sched[k][j].start) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void m_flush();
      for (int k = 0; k < NI; k++) begin
         sched[k].delete();
         err_at[k].delete();
         last_end[k] = -100;
      end
   endfunction

   task automatic cmp(int k, string name, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL inst%0d cyc%0d %s: got %0h expected %0h", k, cyc, name, got, exp);
      end
   endtask

   // Present this cycle's requests and push the resulting expectations.
   task automatic drive_cycle();
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         drv_v[k] = want_v[k];
         drv_i[k] = want_i[k];
         took[k]  = 1'b0;
         if (want_v[k] && m_ready(k, cyc)) begin
            pulse_t p;
            took[k] = 1'b1;
            if (want_i[k] >= NN[k]) begin
               err_at[k].push_back(cyc + 1);
            end else begin
               p.idx   = want_i[k];
               p.acc   = cyc;
               p.start = (last_end[k] >= cyc + 1) ? last_end[k] + 1 : cyc + 1;
               p.fin   = p.start + HH[k] - 1;
               last_end[k] = p.fin;
               sched[k].push_back(p);
            end
         end
      end
   endtask

   task automatic send_held(int k, int idx);
      bit ok;
      ok = 1'b0;
      want_v[k] = 1'b1;
      want_i[k] = idx;
      for (int n = 0; n < 20 && !ok; n++) begin
         drive_cycle();
         ok = took[k];
      end
      want_v[k] = 1'b0;
      if (!ok) begin
         miscompares++;
         $display("FAIL inst%0d held request idx %0d: got not accepted expected accepted within 20 cycles", k, idx);
      end
   endtask

   task automatic one_req(int k, int idx);
      want_v[k] = 1'b1;
      want_i[k] = idx;
      drive_cycle();
      want_v[k] = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive_cycle();
   endtask

   task automatic check(int k, logic [31:0] g_out, logic [31:0] g_busy,
                        logic [31:0] g_done, logic [31:0] g_ready, logic [31:0] g_err);
      int c;
      int eo;
      bit ed;
      bit ee;
      c  = cyc;
      eo = 0;
      ed = 1'b0;
      ee = 1'b0;
      if (sched[k].size() > 0 && sched[k][0].start <= c) begin
         eo = 1 << sched[k][0].idx;
         ed = (c == sched[k][0].fin);
      end
      if (err_at[k].size() > 0 && err_at[k][0] == c) ee = 1'b1;
      cmp(k, "out",   g_out,   32'(eo));
      cmp(k, "busy",  g_busy,  32'(eo != 0));
      cmp(k, "done",  g_done,  32'(ed));
      cmp(k, "ready", g_ready, 32'(m_ready(k, c)));
      cmp(k, "err",   g_err,   32'(ee));
      if (ed) void'(sched[k].pop_front());
      if (ee) void'(err_at[k].pop_front());
   endtask

   always @(negedge clk) begin
      check(0, 32'(bus0.out), 32'(bus0.busy), 32'(bus0.done), 32'(bus0.ready), 32'(bus0.err));
      check(1, 32'(bus1.out), 32'(bus1.busy), 32'(bus1.done), 32'(bus1.ready), 32'(bus1.err));
      check(2, 32'(bus2.out), 32'(bus2.busy), 32'(bus2.done), 32'(bus2.ready), 32'(bus2.err));
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         want_v[k] = 1'b0;
         want_i[k] = 0;
         drv_v[k]  = 1'b0;
         drv_i[k]  = 0;
         took[k]   = 1'b0;
      end
      m_flush();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      idle(2);

      // single pulse
      one_req(0, 2);
      idle(6);

      // back-to-back through the pending buffer
      one_req(0, 0);
      one_req(0, 3);
      idle(9);

      // request arriving only in the done cycle
      one_req(0, 1);
      idle(3);
      one_req(0, 2);
      idle(6);

      // pending full, third request held until it drains
      one_req(0, 0);
      one_req(0, 1);
      send_held(0, 2);
      idle(14);

      // asynchronous reset mid-pulse with pending occupied
      one_req(0, 0);
      one_req(0, 3);
      idle(1);
      #2 rst = 1'b1;
      m_flush();
      #1;
      cmp(0, "rst_out",  32'(bus0.out),  32'd0);
      cmp(0, "rst_busy", 32'(bus0.busy), 32'd0);
      cmp(0, "rst_done", 32'(bus0.done), 32'd0);
      @(posedge clk);
      #4 rst = 1'b0;
      idle(8);

      // out-of-range index on N=3, then a legal one
      one_req(1, 3);
      idle(2);
      one_req(1, 2);
      idle(6);

      // HOLD=1: consecutive one-cycle pulses
      one_req(2, 1);
      one_req(2, 2);
      one_req(2, 3);
      idle(3);

      // randomized traffic; an unaccepted request is held by the upstream
      for (int t = 0; t < 600; t++) begin
         for (int k = 0; k < NI; k++) begin
            if (!want_v[k] || took[k]) begin
               want_v[k] = ($urandom_range(0, 2) != 0);
               want_i[k] = $urandom_range(0, 3);
            end
         end
         drive_cycle();
      end
      for (int k = 0; k < NI; k++) want_v[k] = 1'b0;
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
